// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the test-pattern source: mode encodings and the bar colour table.
// Colours are kept as 3-bit {R,G,B} on/off flags and widened to BITS_PER_COLOR in the top.
package vga_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_BARS    = 3'd0,
    MODE_GRID    = 3'd1,
    MODE_RAMP    = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_SOLID   = 3'd4,
    MODE_BOX     = 3'd5,
    MODE_BORDER  = 3'd6,
    MODE_RSVD    = 3'd7
  } mode_e;

  localparam logic [2:0] RGB_WHITE = 3'b111;
  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;  // white
      3'd1:    rgb = 3'b110;  // yellow
      3'd2:    rgb = 3'b011;  // cyan
      3'd3:    rgb = 3'b010;  // green
      3'd4:    rgb = 3'b101;  // magenta
      3'd5:    rgb = 3'b100;  // red
      3'd6:    rgb = 3'b001;  // blue
      default: rgb = 3'b000;  // black
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_box_mover.sv
// One axis of the animated box: bounces between 0 and size-BOX_SIZE, one step per frame.
// o_pos_d is the position in effect for the frame being rendered (already advanced on i_step).
module pattern_box_mover
  import vga_pattern_pkg::*;
#(
  parameter int CW       = 12,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_step,
  input  logic [CW-1:0] i_size,
  output logic [CW-1:0] o_pos_d
);

  localparam logic [CW:0] SIZE_EXT = (CW+1)'(BOX_SIZE);
  localparam logic [CW:0] STEP_EXT = (CW+1)'(BOX_STEP);

  logic [CW-1:0] pos_q, pos_d, limit;
  logic          dn_q, dn_d;

  always_comb begin
    pos_d = pos_q;
    dn_d  = dn_q;
    limit = i_size - CW'(BOX_SIZE);
    if (i_step) begin
      if ({1'b0, i_size} < SIZE_EXT) begin
        pos_d = '0;
        dn_d  = 1'b0;
      end else if (!dn_q) begin
        if (({1'b0, pos_q} + STEP_EXT) > {1'b0, limit}) begin
          pos_d = limit;
          dn_d  = 1'b1;
        end else begin
          pos_d = pos_q + CW'(BOX_STEP);
        end
      end else begin
        // A narrower new frame can leave the box past the edge; pull it back first.
        if ({1'b0, pos_q} < STEP_EXT) begin
          pos_d = '0;
          dn_d  = 1'b0;
        end else if (pos_q > limit) begin
          pos_d = limit;
        end else begin
          pos_d = pos_q - CW'(BOX_STEP);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pos_q <= '0;
      dn_q  <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dn_q  <= dn_d;
    end
  end

  assign o_pos_d = pos_d;

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode test-pattern source for the HDMI encoder, one pixel per i_rd strobe.
// o_pixel is registered from the next-state coordinates so it always shows the current (x,y).
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int BITS_PER_COLOR = 8,
  parameter int CW             = 12,
  parameter int GRID_LOG2      = 5,
  parameter int CHK_LOG2       = 6,
  parameter int BOX_SIZE       = 32,
  parameter int BOX_STEP       = 2,
  parameter int FRAME_BITS     = 8
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset_n,
  input  logic [CW-1:0]               i_width,
  input  logic [CW-1:0]               i_height,
  input  logic [2:0]                  i_mode,
  input  logic [3*BITS_PER_COLOR-1:0] i_colour,
  input  logic                        i_rd,
  input  logic                        i_newline,
  input  logic                        i_newframe,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel,
  output logic [2:0]                  o_mode,
  output logic [FRAME_BITS-1:0]       o_frame_count
);

  localparam int PW = 3 * BITS_PER_COLOR;
  localparam logic [CW:0] BOX_EXT = (CW+1)'(BOX_SIZE);

  function automatic logic [PW-1:0] expand(input logic [2:0] f);
    return {{BITS_PER_COLOR{f[2]}}, {BITS_PER_COLOR{f[1]}}, {BITS_PER_COLOR{f[0]}}};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CW-1:0]         x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [CW-1:0]         bar_pos_q, bar_pos_d, bx_d, by_d;
  logic [2:0]            bar_idx_q, bar_idx_d;
  mode_e                 mode_q, mode_d;
  logic [PW-1:0]         colour_q, colour_d, pixel_q, pixel_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  active, on_grid, in_box, on_border;
  logic [BITS_PER_COLOR-1:0] ramp_b;

  pattern_box_mover #(.CW(CW), .BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP)) u_box_x (
    .i_clk(i_pixclk), .i_reset_n(i_reset_n), .i_step(i_newframe), .i_size(i_width), .o_pos_d(bx_d)
  );

  pattern_box_mover #(.CW(CW), .BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP)) u_box_y (
    .i_clk(i_pixclk), .i_reset_n(i_reset_n), .i_step(i_newframe), .i_size(i_height), .o_pos_d(by_d)
  );

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    mode_d    = mode_q;
    colour_d  = colour_q;
    frame_d   = frame_q;
    bar_idx_d = bar_idx_q;
    bar_pos_d = bar_pos_q;
    if (i_newframe) begin
      x_d       = '0;
      y_d       = '0;
      w_d       = i_width;
      h_d       = i_height;
      mode_d    = mode_e'(i_mode);
      colour_d  = i_colour;
      frame_d   = frame_q + 1'b1;
      bar_idx_d = '0;
      bar_pos_d = '0;
    end else if (i_newline) begin
      x_d       = '0;
      y_d       = sat_inc(y_q);
      bar_idx_d = '0;
      bar_pos_d = '0;
    end else if (i_rd) begin
      x_d = sat_inc(x_q);
      // Bar 7 absorbs the width%8 remainder, so the counter parks there.
      if (bar_idx_q != 3'd7) begin
        if ((bar_pos_q + 1'b1) == (w_q >> 3)) begin
          bar_idx_d = bar_idx_q + 1'b1;
          bar_pos_d = '0;
        end else begin
          bar_pos_d = bar_pos_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    active    = (x_d < w_d) && (y_d < h_d);
    on_grid   = (x_d[GRID_LOG2-1:0] == '0) || (y_d[GRID_LOG2-1:0] == '0) ||
                (x_d == w_d - 1'b1) || (y_d == h_d - 1'b1);
    in_box    = (x_d >= bx_d) && ({1'b0, x_d} < {1'b0, bx_d} + BOX_EXT) &&
                (y_d >= by_d) && ({1'b0, y_d} < {1'b0, by_d} + BOX_EXT);
    on_border = (x_d == '0) || (y_d == '0) || (x_d == w_d - 1'b1) || (y_d == h_d - 1'b1);
    ramp_b    = BITS_PER_COLOR'({frame_d, {BITS_PER_COLOR{1'b0}}} >> FRAME_BITS);
    case (mode_d)
      MODE_BARS:    pixel_d = expand(bar_rgb(bar_idx_d));
      MODE_GRID:    pixel_d = expand(on_grid ? RGB_WHITE : RGB_BLACK);
      MODE_RAMP:    pixel_d = {BITS_PER_COLOR'(x_d), BITS_PER_COLOR'(y_d), ramp_b};
      MODE_CHECKER: pixel_d = expand((x_d[CHK_LOG2] ^ y_d[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK);
      MODE_SOLID:   pixel_d = colour_d;
      MODE_BOX:     pixel_d = expand(in_box ? RGB_WHITE : RGB_BLUE);
      MODE_BORDER:  pixel_d = expand(on_border ? RGB_WHITE : RGB_BLACK);
      default:      pixel_d = '0;
    endcase
    if (!active) pixel_d = '0;
  end

  // Window registers reset to all-ones so the reset pixel at (0,0) is the white bar.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '1;
      h_q       <= '1;
      mode_q    <= MODE_BARS;
      colour_q  <= '0;
      frame_q   <= '0;
      bar_idx_q <= '0;
      bar_pos_q <= '0;
      pixel_q   <= expand(RGB_WHITE);
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      mode_q    <= mode_d;
      colour_q  <= colour_d;
      frame_q   <= frame_d;
      bar_idx_q <= bar_idx_d;
      bar_pos_q <= bar_pos_d;
      pixel_q   <= pixel_d;
    end
  end

  assign o_pixel       = pixel_q;
  assign o_mode        = mode_q;
  assign o_frame_count = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a 640x480 window: vector table plus corner sequences.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] width = 12'd640, height = 12'd480;
  logic [2:0]  mode = 3'd0;
  logic [23:0] colour = 24'h0;
  logic        rd = 1'b0, nl = 1'b0, nf = 1'b0;
  logic [23:0] pixel;
  logic [2:0]  omode;
  logic [7:0]  fcount;

  int checks = 0;
  int failures = 0;
  int fc_exp = 0;

  always #5 clk = ~clk;

  vga_pattern_gen dut (
    .i_pixclk(clk), .i_reset_n(rst_n), .i_width(width), .i_height(height),
    .i_mode(mode), .i_colour(colour), .i_rd(rd), .i_newline(nl), .i_newframe(nf),
    .o_pixel(pixel), .o_mode(omode), .o_frame_count(fcount)
  );

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [23:0] colour;
    int          x;
    int          y;
    logic [23:0] exp;
    logic [23:0] mask;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [2:0] m, logic [23:0] c, int x, int y,
                              logic [23:0] e, logic [23:0] mk_mask = 24'hFFFFFF);
    vec_t v;
    v.name = n; v.mode = m; v.colour = c; v.x = x; v.y = y; v.exp = e; v.mask = mk_mask;
    return v;
  endfunction

  function automatic logic [23:0] bar_col(int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic f, input logic l, input logic r);
    nf = f; nl = l; rd = r;
    @(posedge clk);
    #1;
    nf = 1'b0; nl = 1'b0; rd = 1'b0;
  endtask

  task automatic new_frame(input logic [2:0] m, input logic [23:0] c);
    mode = m;
    colour = c;
    step(1'b1, 1'b0, 1'b0);
    fc_exp = (fc_exp + 1) % 256;
  endtask

  task automatic go_to(input int x, input int y);
    for (int i = 0; i < y; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < x; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fc_exp = 0;
  endtask

  task automatic box_move(inout int p, inout bit dn, input int size);
    int lim;
    lim = size - 32;
    if (!dn) begin
      if (p + 2 > lim) begin p = lim; dn = 1'b1; end
      else p = p + 2;
    end else begin
      if (p < 2) begin p = 0; dn = 1'b0; end
      else p = p - 2;
    end
  endtask

  initial begin
    int bx, by;
    bit dx, dy;

    vecs.push_back(mk("bars_x0",     3'd0, 24'h0, 0,   0,   24'hFFFFFF));
    vecs.push_back(mk("bars_x79",    3'd0, 24'h0, 79,  0,   24'hFFFFFF));
    vecs.push_back(mk("bars_x80",    3'd0, 24'h0, 80,  2,   24'hFFFF00));
    vecs.push_back(mk("bars_x160",   3'd0, 24'h0, 160, 0,   24'h00FFFF));
    vecs.push_back(mk("bars_x240",   3'd0, 24'h0, 240, 0,   24'h00FF00));
    vecs.push_back(mk("bars_x320",   3'd0, 24'h0, 320, 0,   24'hFF00FF));
    vecs.push_back(mk("bars_x400",   3'd0, 24'h0, 400, 0,   24'hFF0000));
    vecs.push_back(mk("bars_x480",   3'd0, 24'h0, 480, 0,   24'h0000FF));
    vecs.push_back(mk("bars_x560",   3'd0, 24'h0, 560, 0,   24'h000000));
    vecs.push_back(mk("bars_y480",   3'd0, 24'h0, 0,   480, 24'h000000));
    vecs.push_back(mk("grid_0_5",    3'd1, 24'h0, 0,   5,   24'hFFFFFF));
    vecs.push_back(mk("grid_5_5",    3'd1, 24'h0, 5,   5,   24'h000000));
    vecs.push_back(mk("grid_32_7",   3'd1, 24'h0, 32,  7,   24'hFFFFFF));
    vecs.push_back(mk("grid_33_33",  3'd1, 24'h0, 33,  33,  24'h000000));
    vecs.push_back(mk("grid_639_7",  3'd1, 24'h0, 639, 7,   24'hFFFFFF));
    vecs.push_back(mk("grid_5_479",  3'd1, 24'h0, 5,   479, 24'hFFFFFF));
    vecs.push_back(mk("ramp_300_10", 3'd2, 24'h0, 300, 10,  24'h2C0A00, 24'hFFFF00));
    vecs.push_back(mk("chk_0_0",     3'd3, 24'h0, 0,   0,   24'h000000));
    vecs.push_back(mk("chk_64_0",    3'd3, 24'h0, 64,  0,   24'hFFFFFF));
    vecs.push_back(mk("chk_64_64",   3'd3, 24'h0, 64,  64,  24'h000000));
    vecs.push_back(mk("chk_10_70",   3'd3, 24'h0, 10,  70,  24'hFFFFFF));
    vecs.push_back(mk("solid",       3'd4, 24'hABCDEF, 100, 100, 24'hABCDEF));
    vecs.push_back(mk("border_0_5",  3'd6, 24'h0, 0,   5,   24'hFFFFFF));
    vecs.push_back(mk("border_5_5",  3'd6, 24'h0, 5,   5,   24'h000000));
    vecs.push_back(mk("border_639",  3'd6, 24'h0, 639, 3,   24'hFFFFFF));
    vecs.push_back(mk("border_640",  3'd6, 24'h0, 640, 3,   24'h000000));
    vecs.push_back(mk("border_y479", 3'd6, 24'h0, 3,   479, 24'hFFFFFF));
    vecs.push_back(mk("reserved",    3'd7, 24'h0, 10,  10,  24'h000000));

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pixel", pixel, 24'hFFFFFF);
    chk("rst_mode", omode, 3'd0);
    chk("rst_fcount", fcount, 8'd0);
    rst_n = 1'b1;

    // Reset asserted mid-stream, then a full bar line
    new_frame(3'd4, 24'h112233);
    go_to(7, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pixel", pixel, 24'hFFFFFF);
    chk("midrst_mode", omode, 3'd0);
    chk("midrst_fcount", fcount, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fc_exp = 0;
    new_frame(3'd0, 24'h0);
    for (int x = 0; x < 640; x++) begin
      chk($sformatf("barline_x%0d", x), pixel, bar_col(x / 80));
      step(1'b0, 1'b0, 1'b1);
    end
    chk("barline_x640", pixel, 24'h000000);

    // Vector table
    foreach (vecs[i]) begin
      new_frame(vecs[i].mode, vecs[i].colour);
      go_to(vecs[i].x, vecs[i].y);
      chk(vecs[i].name, pixel & vecs[i].mask, vecs[i].exp);
      chk({vecs[i].name, "_mode"}, omode, vecs[i].mode);
      chk({vecs[i].name, "_fcount"}, fcount, fc_exp);
    end

    // Mode and colour changes take effect only at the next frame
    new_frame(3'd4, 24'h123456);
    go_to(10, 0);
    mode = 3'd3;
    colour = 24'hABCDEF;
    go_to(5, 0);
    chk("midframe_pixel", pixel, 24'h123456);
    chk("midframe_mode", omode, 3'd4);
    step(1'b0, 1'b1, 1'b0);
    chk("midframe_newline", pixel, 24'h123456);
    new_frame(3'd3, 24'hABCDEF);
    chk("switch_mode", omode, 3'd3);
    chk("switch_pixel00", pixel, 24'h000000);
    go_to(64, 0);
    chk("switch_pixel64", pixel, 24'hFFFFFF);

    // Simultaneous strobes: newframe wins
    new_frame(3'd2, 24'h0);
    go_to(5, 3);
    mode = 3'd2;
    step(1'b1, 1'b1, 1'b1);
    fc_exp = (fc_exp + 1) % 256;
    chk("prio_fcount", fcount, fc_exp);
    chk("prio_pixel", pixel, fc_exp);
    step(1'b0, 1'b0, 1'b1);
    chk("prio_next", pixel, 24'h010000 | fc_exp);

    // Overrun past the line end shows black
    new_frame(3'd4, 24'h123456);
    chk("overrun_x0", pixel, 24'h123456);
    go_to(639, 0);
    chk("overrun_x639", pixel, 24'h123456);
    for (int x = 640; x < 650; x++) begin
      step(1'b0, 1'b0, 1'b1);
      chk($sformatf("overrun_x%0d", x), pixel, 24'h000000);
    end

    // Box bounce over 400 frames, sampled every 25 frames
    do_reset();
    bx = 0; by = 0; dx = 1'b0; dy = 1'b0;
    for (int f = 1; f <= 400; f++) begin
      new_frame(3'd5, 24'h0);
      box_move(bx, dx, 640);
      box_move(by, dy, 480);
      if (f % 25 == 0) begin
        if (bx > 0) begin
          go_to(bx - 1, by);
          chk($sformatf("box_f%0d_left", f), pixel, 24'h0000FF);
          step(1'b0, 1'b0, 1'b1);
        end else begin
          go_to(0, by);
        end
        chk($sformatf("box_f%0d_corner", f), pixel, 24'hFFFFFF);
        go_to(31, 0);
        chk($sformatf("box_f%0d_edge", f), pixel, 24'hFFFFFF);
        step(1'b0, 1'b0, 1'b1);
        chk($sformatf("box_f%0d_right", f), pixel, (bx + 32 < 640) ? 24'h0000FF : 24'h000000);
      end
    end
    chk("box_fcount", fcount, fc_exp);

    // Frame counter wrap and RAMP blue channel
    do_reset();
    for (int f = 0; f < 255; f++) new_frame(3'd2, 24'h0);
    chk("wrap_ff", fcount, 8'hFF);
    chk("wrap_ff_pixel", pixel, 24'h0000FF);
    chk("wrap_ff_mode", omode, 3'd2);
    new_frame(3'd2, 24'h0);
    chk("wrap_00", fcount, 8'h00);
    chk("wrap_00_pixel", pixel, 24'h000000);
    step(1'b0, 1'b0, 1'b1);
    chk("wrap_00_x1", pixel, 24'h010000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
